// File: rtl/lda_projector.sv
// LDA projection back end: picks the dominant eigenvector from the eigen-solver,
// converts it to signed fixed-point weights and streams samples through a 2-stage MAC.
module lda_projector #(
  parameter int DW    = 16,
  parameter int WW    = 16,
  parameter int WFRAC = 14,
  parameter int EW    = 40,
  parameter int EFRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  input  logic                 sign_ev1,
  input  logic [23:0]          ans_ev1,
  input  logic [7:0]           temp_ev1,
  input  logic                 sign_ev2,
  input  logic [23:0]          ans_ev2,
  input  logic [7:0]           temp_ev2,
  input  logic                 sign_v1x,
  input  logic [23:0]          ans_v1x,
  input  logic [7:0]           temp_v1x,
  input  logic                 sign_v1y,
  input  logic [23:0]          ans_v1y,
  input  logic [7:0]           temp_v1y,
  input  logic                 sign_v2x,
  input  logic [23:0]          ans_v2x,
  input  logic [7:0]           temp_v2x,
  input  logic                 sign_v2y,
  input  logic [23:0]          ans_v2y,
  input  logic [7:0]           temp_v2y,
  input  logic signed [DW+WW:0] threshold,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_x,
  input  logic signed [DW-1:0] in_y,
  output logic                 out_valid,
  output logic signed [DW+WW:0] out_proj,
  output logic                 out_class,
  output logic                 sel_ev,
  output logic                 w_sat,
  output logic [2:0]           state_dbg
);
  // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on the FSM state, and the output side has no backpressure.
  localparam int PW = DW + WW;
  localparam int OW = DW + WW + 1;

  typedef enum logic [2:0] {IDLE, CMP, CONV_X, CONV_Y, READY} state_t;
  typedef struct packed {
    logic        sign;
    logic [23:0] ans;
    logic [7:0]  temp;
  } triple_t;

  state_t               state, next_state;
  logic                 load_accept;
  triple_t              ev1_r, ev2_r, v1x_r, v1y_r, v2x_r, v2y_r, conv_src;
  logic [63:0]          ev1_raw, ev2_raw, w_raw;
  logic [EW-1:0]        ev1_mag, ev2_mag;
  logic                 w_over;
  logic [WW-2:0]        w_mag;
  logic signed [WW-1:0] w_val, wx, wy;
  logic                 accept, s1_valid;
  logic signed [PW-1:0] px, py;
  logic signed [OW-1:0] sum;
  logic                 unused_ev_signs;

  // ans * 2^(frac - temp), truncating; 64 bits holds the largest left shift.
  function automatic logic [63:0] scale(input logic [23:0] ans, input logic [7:0] temp,
                                        input logic [7:0] frac);
    logic [63:0] wide;
    wide = {40'd0, ans};
    if (temp <= frac) scale = wide << (frac - temp);
    else              scale = wide >> (temp - frac);
  endfunction

  assign state_dbg       = state;
  assign in_ready        = (state == READY);
  assign accept          = in_valid && in_ready;
  assign unused_ev_signs = ev1_r.sign ^ ev2_r.sign;

  always_comb begin
    next_state  = state;
    load_accept = 1'b0;
    case (state)
      IDLE:    if (load_valid) begin load_accept = 1'b1; next_state = CMP; end
      CMP:     next_state = CONV_X;
      CONV_X:  next_state = CONV_Y;
      CONV_Y:  next_state = READY;
      READY:   if (load_valid) begin load_accept = 1'b1; next_state = CMP; end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ev1_raw  = scale(ev1_r.ans, ev1_r.temp, 8'(EFRAC));
    ev2_raw  = scale(ev2_r.ans, ev2_r.temp, 8'(EFRAC));
    ev1_mag  = (|ev1_raw[63:EW]) ? {EW{1'b1}} : ev1_raw[EW-1:0];
    ev2_mag  = (|ev2_raw[63:EW]) ? {EW{1'b1}} : ev2_raw[EW-1:0];
    // One converter shared by both components; the state picks which one it serves.
    if (state == CONV_X) conv_src = sel_ev ? v2x_r : v1x_r;
    else                 conv_src = sel_ev ? v2y_r : v1y_r;
    w_raw  = scale(conv_src.ans, conv_src.temp, 8'(WFRAC));
    w_over = |w_raw[63:WW-1];
    w_mag  = w_over ? {(WW-1){1'b1}} : w_raw[WW-2:0];
    w_val  = conv_src.sign ? -$signed({1'b0, w_mag}) : $signed({1'b0, w_mag});
    sum    = OW'(px) + OW'(py);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ev1_r  <= '0;
      ev2_r  <= '0;
      v1x_r  <= '0;
      v1y_r  <= '0;
      v2x_r  <= '0;
      v2y_r  <= '0;
      sel_ev <= 1'b0;
      w_sat  <= 1'b0;
      wx     <= '0;
      wy     <= '0;
    end else begin
      state <= next_state;
      if (load_accept) begin
        ev1_r <= '{sign_ev1, ans_ev1, temp_ev1};
        ev2_r <= '{sign_ev2, ans_ev2, temp_ev2};
        v1x_r <= '{sign_v1x, ans_v1x, temp_v1x};
        v1y_r <= '{sign_v1y, ans_v1y, temp_v1y};
        v2x_r <= '{sign_v2x, ans_v2x, temp_v2x};
        v2y_r <= '{sign_v2y, ans_v2y, temp_v2y};
        w_sat <= 1'b0;
      end
      if (state == CMP) sel_ev <= (ev2_mag > ev1_mag);
      if (state == CONV_X) begin
        wx <= w_val;
        if (w_over) w_sat <= 1'b1;
      end
      if (state == CONV_Y) begin
        wy <= w_val;
        if (w_over) w_sat <= 1'b1;
      end
    end
  end

  // Weights only change outside READY, so in-flight samples keep the old ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      px        <= '0;
      py        <= '0;
      out_valid <= 1'b0;
      out_proj  <= '0;
      out_class <= 1'b0;
    end else begin
      s1_valid  <= accept;
      if (accept) begin
        px <= PW'(wx) * PW'(in_x);
        py <= PW'(wy) * PW'(in_y);
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_proj  <= sum;
        out_class <= (sum >= threshold);
      end
    end
  end
endmodule

// File: tb/tb_lda_projector.sv
// Bench for lda_projector: directed scenarios plus random loads/samples checked
// against an arithmetic model of eigenvector selection, weight scaling and projection.
module tb_lda_projector;
  typedef struct { bit s; int unsigned a; int unsigned t; } trip_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               load_valid = 1'b0;
  logic               sign_ev1 = 0, sign_ev2 = 0, sign_v1x = 0, sign_v1y = 0, sign_v2x = 0, sign_v2y = 0;
  logic [23:0]        ans_ev1 = 0, ans_ev2 = 0, ans_v1x = 0, ans_v1y = 0, ans_v2x = 0, ans_v2y = 0;
  logic [7:0]         temp_ev1 = 0, temp_ev2 = 0, temp_v1x = 0, temp_v1y = 0, temp_v2x = 0, temp_v2y = 0;
  logic signed [32:0] threshold = 0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_x = 0, in_y = 0;
  logic               out_valid;
  logic signed [32:0] out_proj;
  logic               out_class, sel_ev, w_sat;
  logic [2:0]         state_dbg;

  int          tests = 0, failed = 0, cyc = 0;
  logic [33:0] exp_q[$];
  int          due_q[$];
  logic [33:0] mon_e;
  int          mon_d;
  trip_t       nt[6];  // ev1, ev2, v1x, v1y, v2x, v2y
  int          m_wx = 0, m_wy = 0;
  bit          m_sel = 0, m_sat = 0;

  lda_projector dut (
    .clk(clk), .rst(rst), .load_valid(load_valid),
    .sign_ev1(sign_ev1), .ans_ev1(ans_ev1), .temp_ev1(temp_ev1),
    .sign_ev2(sign_ev2), .ans_ev2(ans_ev2), .temp_ev2(temp_ev2),
    .sign_v1x(sign_v1x), .ans_v1x(ans_v1x), .temp_v1x(temp_v1x),
    .sign_v1y(sign_v1y), .ans_v1y(ans_v1y), .temp_v1y(temp_v1y),
    .sign_v2x(sign_v2x), .ans_v2x(ans_v2x), .temp_v2x(temp_v2x),
    .sign_v2y(sign_v2y), .ans_v2y(ans_v2y), .temp_v2y(temp_v2y),
    .threshold(threshold), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_proj(out_proj),
    .out_class(out_class), .sel_ev(sel_ev), .w_sat(w_sat), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: value = ans * 2^(F - temp), truncated toward zero.
  function automatic longint unsigned pow2(input int n);
    pow2 = 1;
    repeat (n) pow2 = pow2 * 2;
  endfunction

  function automatic longint unsigned conv(input trip_t v, input int f);
    if (int'(v.t) <= f) return longint'(v.a) * pow2(f - int'(v.t));
    if (int'(v.t) - f >= 40) return 0;
    return longint'(v.a) / pow2(int'(v.t) - f);
  endfunction

  function automatic void model_update();
    longint unsigned e1, e2, mx, my;
    trip_t tx, ty;
    e1 = conv(nt[0], 8);
    e2 = conv(nt[1], 8);
    if (e1 > 64'hFF_FFFF_FFFF) e1 = 64'hFF_FFFF_FFFF;
    if (e2 > 64'hFF_FFFF_FFFF) e2 = 64'hFF_FFFF_FFFF;
    m_sel = (e2 > e1);
    tx = m_sel ? nt[4] : nt[2];
    ty = m_sel ? nt[5] : nt[3];
    mx = conv(tx, 14);
    my = conv(ty, 14);
    m_sat = (mx > 32767) || (my > 32767);
    if (mx > 32767) mx = 32767;
    if (my > 32767) my = 32767;
    m_wx = tx.s ? -int'(mx) : int'(mx);
    m_wy = ty.s ? -int'(my) : int'(my);
  endfunction

  function automatic void push_exp(input int x, input int y);
    longint proj;
    bit cls;
    proj = longint'(m_wx) * x + longint'(m_wy) * y;
    cls  = (proj >= longint'(threshold));
    exp_q.push_back({cls, 33'(proj)});
    due_q.push_back(cyc + 2);
  endfunction

  function automatic void set_trip(input int i, input bit s, input int unsigned a, input int unsigned t);
    nt[i].s = s; nt[i].a = a; nt[i].t = t;
  endfunction

  function automatic trip_t rand_trip(input int unsigned maxt);
    trip_t r;
    r.s = 1'($urandom_range(0, 1));
    r.a = $urandom_range(0, 1) ? $urandom_range(0, 24'hFFFFFF) : $urandom_range(0, 4095);
    r.t = $urandom_range(0, maxt);
    return r;
  endfunction

  function automatic void apply_pins();
    sign_ev1 = nt[0].s; ans_ev1 = nt[0].a[23:0]; temp_ev1 = nt[0].t[7:0];
    sign_ev2 = nt[1].s; ans_ev2 = nt[1].a[23:0]; temp_ev2 = nt[1].t[7:0];
    sign_v1x = nt[2].s; ans_v1x = nt[2].a[23:0]; temp_v1x = nt[2].t[7:0];
    sign_v1y = nt[3].s; ans_v1y = nt[3].a[23:0]; temp_v1y = nt[3].t[7:0];
    sign_v2x = nt[4].s; ans_v2x = nt[4].a[23:0]; temp_v2x = nt[4].t[7:0];
    sign_v2y = nt[5].s; ans_v2y = nt[5].a[23:0]; temp_v2y = nt[5].t[7:0];
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Scoreboard: in-order results with exact latency
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_out: out_valid=1 proj=%0d at cycle %0d, required no output", out_proj, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_d = due_q.pop_front();
          if ({out_class, out_proj} !== mon_e || mon_d != cyc) begin
            failed++;
            $display("FAIL projection: got class=%0b proj=%0d at cycle %0d, required class=%0b proj=%0d at cycle %0d",
                     out_class, out_proj, cyc, mon_e[33], $signed(mon_e[32:0]), mon_d);
          end
        end
      end else if (due_q.size() > 0 && due_q[0] < cyc) begin
        tests++;
        failed++;
        $display("FAIL missing_out: no out_valid by cycle %0d, required result due at cycle %0d", cyc, due_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic check_load(input bit glitch);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'(i == 4)) begin
        failed++;
        $display("FAIL ready_ramp: cycle L+%0d in_ready=%b, required %b", i, in_ready, i == 4);
      end
    end
    if (glitch) begin
      load_valid = 1'b0;
      apply_pins();
    end
    in_valid = 1'b0;
    tests++;
    if (sel_ev !== m_sel) begin
      failed++;
      $display("FAIL sel_ev: got %b, required %b", sel_ev, m_sel);
    end
    tests++;
    if (w_sat !== m_sat) begin
      failed++;
      $display("FAIL w_sat: got %b, required %b", w_sat, m_sat);
    end
  endtask

  task automatic do_load(input bit glitch);
    @(posedge clk); #1;
    in_valid = 1'b0;
    apply_pins();
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = glitch;
    if (glitch) begin  // loads during CMP/CONV_X/CONV_Y must be ignored
      ans_ev1 = 24'd1; ans_ev2 = 24'hFFFFFF; temp_ev2 = 8'd0;
      ans_v1x = ~ans_v1x; ans_v1y = ~ans_v1y; ans_v2x = ~ans_v2x; ans_v2y = ~ans_v2y;
      sign_v1x = ~sign_v1x; sign_v2y = ~sign_v2y;
    end
    model_update();
    check_load(glitch);
  endtask

  task automatic send_xy(input int x, input int y);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_x = 16'(x);
    in_y = 16'(y);
    push_exp(x, y);
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask

  // Scenarios
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({in_ready, out_valid, out_class, sel_ev, w_sat} !== 5'b0 || out_proj !== 33'sd0) begin
      failed++;
      $display("FAIL reset_state: ready=%b valid=%b class=%b sel=%b sat=%b proj=%0d, required all 0",
               in_ready, out_valid, out_class, sel_ev, w_sat, out_proj);
    end
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin  // IDLE must not accept samples
      in_x = 16'(rand_sample());
      in_y = 16'(rand_sample());
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0) begin
        failed++;
        $display("FAIL idle_ready: got %b, required 0", in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    set_trip(0, 0, 3, 0); set_trip(1, 0, 5, 0);
    set_trip(2, 0, 7, 3); set_trip(3, 1, 9, 2);
    set_trip(4, 0, 1, 1); set_trip(5, 0, 1, 0);
    threshold = 0;
    do_load(1'b0);
    send_xy(100, -20);
    send_xy(1, 0);
    send_xy(0, 1);
    drain();
  endtask

  task automatic test_tie_negative();
    set_trip(0, 0, 4, 0); set_trip(1, 1, 4, 0);
    set_trip(2, 1, 1, 0); set_trip(3, 0, 0, 0);
    set_trip(4, 0, 9, 0); set_trip(5, 0, 9, 0);
    threshold = 0;
    do_load(1'b0);
    send_xy(10, 7);
    send_xy(1, 0);
    send_xy(-3, 200);
    drain();
  endtask

  task automatic test_saturation();
    set_trip(0, 0, 100, 0); set_trip(1, 0, 1, 0);
    set_trip(2, 0, 24'hFFFFFF, 0); set_trip(3, 1, 5, 3);
    set_trip(4, 0, 1, 0); set_trip(5, 0, 1, 0);
    threshold = 33'sd1000;
    do_load(1'b0);
    send_xy(1, 0);
    send_xy(-32768, 32767);
    drain();
    set_trip(2, 0, 1, 2);  // normal load clears w_sat
    do_load(1'b0);
    send_xy(50, 50);
    drain();
  endtask

  task automatic test_back_to_back();
    logic signed [32:0] last_p;
    logic last_c;
    for (int i = 0; i < 8; i++) send_xy(rand_sample(), rand_sample());
    drain();
    last_p = out_proj;
    last_c = out_class;
    repeat (3) @(negedge clk);
    tests++;
    if (out_proj !== last_p || out_class !== last_c) begin
      failed++;
      $display("FAIL hold: proj=%0d class=%b, required held proj=%0d class=%b", out_proj, out_class, last_p, last_c);
    end
  endtask

  task automatic test_ignored_load();
    for (int i = 0; i < 6; i++) nt[i] = rand_trip(20);
    do_load(1'b1);
    send_xy(rand_sample(), rand_sample());
    send_xy(1, 1);
    drain();
  endtask

  task automatic test_random_loads();
    for (int r = 0; r < 6; r++) begin
      nt[0] = rand_trip(20);
      nt[1] = rand_trip(20);
      for (int i = 2; i < 6; i++) nt[i] = rand_trip(30);
      threshold = 33'(int'($urandom_range(0, 2000000)) - 1000000);
      do_load(1'b0);
      for (int k = 0; k < 6; k++) send_xy(rand_sample(), rand_sample());
      drain();
    end
  endtask

  task automatic test_reload_midstream();
    send_xy(rand_sample(), rand_sample());
    send_xy(rand_sample(), rand_sample());  // accepted in the same cycle as the load
    for (int i = 0; i < 6; i++) nt[i] = rand_trip(25);
    apply_pins();
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    in_x = 16'(rand_sample());  // in_valid stays high while not ready
    model_update();
    check_load(1'b0);
    for (int k = 0; k < 4; k++) send_xy(rand_sample(), rand_sample());
    drain();
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_x = 16'(rand_sample());
    in_y = 16'(rand_sample());
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst = 1'b1;
    exp_q.delete();
    due_q.delete();
    #1;
    tests++;
    if ({in_ready, out_valid, out_class, sel_ev, w_sat} !== 5'b0 || out_proj !== 33'sd0) begin
      failed++;
      $display("FAIL async_reset: ready=%b valid=%b class=%b sel=%b sat=%b proj=%0d, required all 0",
               in_ready, out_valid, out_class, sel_ev, w_sat, out_proj);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failed++;
        $display("FAIL post_reset: in_ready=%b out_valid=%b, required 0 0", in_ready, out_valid);
      end
    end
    set_trip(0, 0, 3, 0); set_trip(1, 0, 5, 0);
    set_trip(4, 1, 3, 4); set_trip(5, 0, 1, 0);
    do_load(1'b0);
    send_xy(3, 4);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie_negative();
    test_saturation();
    test_back_to_back();
    test_ignored_load();
    test_random_loads();
    test_reload_midstream();
    test_async_reset();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
